// File: rtl/pmod_ssd_capture_if.sv
// Signal bundle between a PmodSSD transmitter (or loopback source) and the capture monitor.
`timescale 1ns / 1ps

interface pmod_ssd_capture_if;
    logic [7:0] i_ssd_pmod;
    logic [7:0] o_value;
    logic       o_valid;
    logic       o_seg_err;
    logic [7:0] o_err_count;
    logic       o_timeout;
    logic       o_locked;

    modport master (
        output i_ssd_pmod,
        input  o_value,
        input  o_valid,
        input  o_seg_err,
        input  o_err_count,
        input  o_timeout,
        input  o_locked
    );

    modport slave (
        input  i_ssd_pmod,
        output o_value,
        output o_valid,
        output o_seg_err,
        output o_err_count,
        output o_timeout,
        output o_locked
    );
endinterface

// File: rtl/pmod_ssd_capture.sv
// Receive-side PmodSSD monitor: synchronizes and debounces the bus, decodes both digits back to
// a byte, counts illegal patterns and flags loss of digit-select multiplexing.
`timescale 1ns / 1ps

module pmod_ssd_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 600000
) (
    input logic               i_clk_20mhz,
    input logic               i_rst_20mhz_n,
    pmod_ssd_capture_if.slave bus
);
    localparam int unsigned    ToW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]     SettleMax = 8'(SETTLE_CYCLES);
    localparam logic [ToW-1:0] ToMax     = ToW'(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0] ToLast    = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_HUNT, S_GOT1} state_e;

    logic [7:0]     sync1_q, sync2_q, prev_q, last_acc_q;
    logic [7:0]     stab_q, stab_d;
    logic [ToW-1:0] to_q, to_d;
    state_e         state_q, state_d;
    logic [3:0]     left_q, left_d;
    logic [7:0]     value_q, value_d;
    logic           valid_q, valid_d;
    logic           seg_err_q, seg_err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           timeout_q, timeout_d;
    logic           locked_q, locked_d;

    logic       accept, toggle, expire;
    logic       seg_blank, seg_illegal;
    logic [3:0] digit;

    always_comb begin
        digit       = 4'h0;
        seg_blank   = 1'b0;
        seg_illegal = 1'b0;
        case (sync2_q[6:0])
            7'h3F:   digit = 4'h0;
            7'h06:   digit = 4'h1;
            7'h5B:   digit = 4'h2;
            7'h4F:   digit = 4'h3;
            7'h66:   digit = 4'h4;
            7'h6D:   digit = 4'h5;
            7'h7D:   digit = 4'h6;
            7'h07:   digit = 4'h7;
            7'h7F:   digit = 4'h8;
            7'h67:   digit = 4'h9;
            7'h77:   digit = 4'hA;
            7'h7C:   digit = 4'hB;
            7'h39:   digit = 4'hC;
            7'h5E:   digit = 4'hD;
            7'h79:   digit = 4'hE;
            7'h71:   digit = 4'hF;
            7'h00:   seg_blank = 1'b1;
            default: seg_illegal = 1'b1;
        endcase
    end

    // Accept fires once per stable run, on the cycle the counter first reaches its limit.
    always_comb begin
        stab_d = stab_q;
        if (sync2_q != prev_q) begin
            stab_d = '0;
        end else if (stab_q != SettleMax) begin
            stab_d = stab_q + 8'd1;
        end
        accept = (stab_d == SettleMax) && (stab_q != SettleMax) && (sync2_q != last_acc_q);
        toggle = accept && (sync2_q[7] != last_acc_q[7]);
        expire = !toggle && (to_q == ToLast);
        if (toggle) begin
            to_d = '0;
        end else if (to_q == ToMax) begin
            to_d = to_q;
        end else begin
            to_d = to_q + ToW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        seg_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        timeout_d = timeout_q;
        locked_d  = locked_q;
        if (accept) begin
            if (seg_illegal) begin
                seg_err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = S_HUNT;
            end else if (seg_blank) begin
                state_d = S_HUNT;
            end else if (sync2_q[7]) begin
                left_d  = digit;
                state_d = S_GOT1;
            end else if (state_q == S_GOT1) begin
                value_d  = {left_q, digit};
                valid_d  = 1'b1;
                locked_d = 1'b1;
                state_d  = S_HUNT;
            end
        end
        if (toggle) begin
            timeout_d = 1'b0;
        end
        if (expire) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = S_HUNT;
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
        if (!i_rst_20mhz_n) begin
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            prev_q     <= 8'h00;
            last_acc_q <= 8'h00;
            stab_q     <= '0;
            to_q       <= '0;
        end else begin
            sync1_q <= bus.i_ssd_pmod;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            to_q    <= to_d;
            if (accept) begin
                last_acc_q <= sync2_q;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
        if (!i_rst_20mhz_n) begin
            state_q   <= S_HUNT;
            left_q    <= 4'h0;
            value_q   <= 8'h00;
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
            err_cnt_q <= 8'h00;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            seg_err_q <= seg_err_d;
            err_cnt_q <= err_cnt_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.o_value     = value_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_seg_err   = seg_err_q;
    assign bus.o_err_count = err_cnt_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_locked    = locked_q;
endmodule

// File: tb/tb_pmod_ssd_capture.sv
// Bench for pmod_ssd_capture: directed vector table, timeout/reset/saturation sequences and a
// randomized run, all checked against a word-level reference model.
`timescale 1ns / 1ps

module tb_pmod_ssd_capture;
    localparam int S = 4;
    localparam int T = 100;
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #25 clk = ~clk;

    pmod_ssd_capture_if u_if ();

    pmod_ssd_capture #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) u_dut (
        .i_clk_20mhz  (clk),
        .i_rst_20mhz_n(rst_n),
        .bus          (u_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word counts as accepted once it has been captured S+1 edges in a row;
    // its effect shows two edges later (synchronizer depth).
    logic [7:0] m_cap, m_lacc, m_value, m_err;
    logic [3:0] m_left;
    int         m_run, m_to;
    bit         m_have_left, m_valid, m_seg, m_timeout, m_locked;
    bit         pv [2];
    logic [7:0] pw [2];

    function automatic int dec(input logic [6:0] p);
        if (p == 7'h00) return 16;
        for (int i = 0; i < 16; i++) if (SEG[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_cap = 8'h00; m_run = 3; m_lacc = 8'h00; m_value = 8'h00; m_err = 8'h00;
        m_left = 4'h0; m_to = 0; m_have_left = 0; m_valid = 0; m_seg = 0;
        m_timeout = 0; m_locked = 0;
        pv[0] = 0; pv[1] = 0; pw[0] = 8'h00; pw[1] = 8'h00;
    endtask

    task automatic model_step();
        bit         acc, tog;
        logic [7:0] w;
        int         d;
        acc = pv[1]; w = pw[1];
        pv[1] = pv[0]; pw[1] = pw[0];
        if (u_if.i_ssd_pmod == m_cap) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_cap = u_if.i_ssd_pmod;
            m_run = 1;
        end
        pv[0] = (m_run == S + 1);
        pw[0] = m_cap;
        m_valid = 0; m_seg = 0; tog = 0;
        if (acc && w != m_lacc) begin
            tog = (w[7] != m_lacc[7]);
            m_lacc = w;
            d = dec(w[6:0]);
            if (d < 0) begin
                m_seg = 1;
                if (m_err < 8'd255) m_err++;
                m_have_left = 0;
            end else if (d == 16) begin
                m_have_left = 0;
            end else if (w[7]) begin
                m_left = d[3:0];
                m_have_left = 1;
            end else if (m_have_left) begin
                m_value = {m_left, d[3:0]};
                m_valid = 1; m_locked = 1; m_have_left = 0;
            end
        end
        if (tog) begin
            m_to = 0;
            m_timeout = 0;
        end else if (m_to < T) begin
            m_to++;
            if (m_to == T) begin
                m_timeout = 1; m_locked = 0; m_have_left = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model_value", u_if.o_value, m_value);
                chk("model_valid", u_if.o_valid, m_valid);
                chk("model_seg_err", u_if.o_seg_err, m_seg);
                chk("model_err_count", u_if.o_err_count, m_err);
                chk("model_timeout", u_if.o_timeout, m_timeout);
                chk("model_locked", u_if.o_locked, m_locked);
            end
        end
    end

    // Applies w at the current negedge and watches the outputs for hold cycles.
    task automatic drive(input logic [7:0] w, input int hold, output int lat, output int nvalid,
                         output int nerr);
        u_if.i_ssd_pmod = w;
        lat = 0; nvalid = 0; nerr = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (u_if.o_valid) begin
                nvalid++;
                if (lat == 0) lat = i;
            end
            if (u_if.o_seg_err) nerr++;
        end
    endtask

    typedef struct {
        logic [7:0] w;
        int         hold;
        int         lat;
        logic [7:0] val;
        logic       lock;
        int         ecnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int lat, nv, ne, prev_e, k, sum;
        logic [7:0] w;
        tbl[0]  = '{8'hFF, 20, 0, 8'h00, 1'b0, 0};
        tbl[1]  = '{8'h06, 20, 7, 8'h81, 1'b1, 0};
        tbl[2]  = '{8'hE6, 20, 0, 8'h81, 1'b1, 0};
        tbl[3]  = '{8'h3F, 3,  0, 8'h81, 1'b1, 0};
        tbl[4]  = '{8'hE6, 20, 0, 8'h81, 1'b1, 0};
        tbl[5]  = '{8'h5B, 20, 7, 8'h42, 1'b1, 0};
        tbl[6]  = '{8'hF7, 20, 0, 8'h42, 1'b1, 0};
        tbl[7]  = '{8'h55, 20, 0, 8'h42, 1'b1, 1};
        tbl[8]  = '{8'h3F, 20, 0, 8'h42, 1'b1, 1};
        tbl[9]  = '{8'hF9, 20, 0, 8'h42, 1'b1, 1};
        tbl[10] = '{8'h71, 20, 7, 8'hEF, 1'b1, 1};

        u_if.i_ssd_pmod = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_value", u_if.o_value, 8'h00);
        chk("rst_valid", u_if.o_valid, 0);
        chk("rst_err_count", u_if.o_err_count, 0);
        chk("rst_timeout", u_if.o_timeout, 0);
        chk("rst_locked", u_if.o_locked, 0);
        rst_n = 1'b1;

        prev_e = 0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].w, tbl[i].hold, lat, nv, ne);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_valids", i), nv, (tbl[i].lat != 0) ? 1 : 0);
            chk($sformatf("vec%0d_seg_errs", i), ne, tbl[i].ecnt - prev_e);
            chk($sformatf("vec%0d_value", i), u_if.o_value, tbl[i].val);
            chk($sformatf("vec%0d_locked", i), u_if.o_locked, tbl[i].lock);
            chk($sformatf("vec%0d_err_count", i), u_if.o_err_count, tbl[i].ecnt);
            prev_e = tbl[i].ecnt;
        end

        // Timeout: hold the right digit after a completed pair.
        drive(8'h86, 20, lat, nv, ne);
        drive(8'h06, 20, lat, nv, ne);
        chk("to_pair_latency", lat, 7);
        chk("to_pair_value", u_if.o_value, 8'h11);
        k = 0;
        for (int i = 21 - lat; i <= 150; i++) begin
            @(negedge clk);
            if (u_if.o_timeout) begin
                k = i;
                break;
            end
        end
        chk("to_cycles_after_toggle", k, 100);
        chk("to_locked", u_if.o_locked, 0);
        chk("to_value_held", u_if.o_value, 8'h11);
        repeat (10) @(negedge clk);
        chk("to_still_set", u_if.o_timeout, 1);
        drive(8'hBF, 20, lat, nv, ne);
        chk("to_cleared", u_if.o_timeout, 0);
        chk("to_relock_pending", u_if.o_locked, 0);
        drive(8'h3F, 20, lat, nv, ne);
        chk("to_recover_latency", lat, 7);
        chk("to_recover_value", u_if.o_value, 8'h00);
        chk("to_recover_locked", u_if.o_locked, 1);

        // Randomized words and holds; the model checks every cycle.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                7:       w = 8'h00;
                8, 9:    w = 8'($urandom_range(0, 127));
                default: w = {1'b0, SEG[$urandom_range(0, 15)]};
            endcase
            w[7] = 1'($urandom_range(0, 1));
            drive(w, ($urandom_range(0, 24) == 0) ? 110 : $urandom_range(1, 10), lat, nv, ne);
        end

        // Reset in the middle of a pair.
        drive(8'h80, 20, lat, nv, ne);
        drive(8'hCF, 20, lat, nv, ne);
        #5 rst_n = 1'b0;
        #0.5;
        chk("mid_rst_value", u_if.o_value, 8'h00);
        chk("mid_rst_valid", u_if.o_valid, 0);
        chk("mid_rst_seg_err", u_if.o_seg_err, 0);
        chk("mid_rst_err_count", u_if.o_err_count, 0);
        chk("mid_rst_timeout", u_if.o_timeout, 0);
        chk("mid_rst_locked", u_if.o_locked, 0);
        #0.5 rst_n = 1'b1;
        u_if.i_ssd_pmod = 8'h67;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.o_valid) nv++;
        end
        chk("mid_rst_no_valid", nv, 0);
        chk("mid_rst_value_after", u_if.o_value, 8'h00);

        // Error counter saturation.
        sum = 0;
        for (int i = 0; i < 260; i++) begin
            drive((i % 2 == 0) ? 8'hD5 : 8'h55, 8, lat, nv, ne);
            sum += ne;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.o_seg_err) sum++;
        end
        chk("sat_seg_err_pulses", sum, 260);
        chk("sat_err_count", u_if.o_err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
